keystroke_controller: RTL and testbench

Sequences raw PS/2 scan bytes into text-buffer edits for the on-screen terminal. Strips break (F0) and extended (E0) sequences and drives the existing scan-code-to-sprite translator with each accepted make code. It then acts on the returned character code: writes a character cell, moves the cursor, or scrolls the view. It sits between the PS/2 receiver and the character RAM write port, and owns the cursor and view-row state.

---
 rtl/keystroke_controller.sv | 173 +++++++++++++++++
 tb/tb_keystroke_controller.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keystroke_controller.sv
// PS/2 scan-byte sequencer: strips break/extended prefixes, looks up each make code
// through the external translator and turns the result into cell writes, cursor moves or scrolls.
module keystroke_controller #(
    parameter int unsigned COLS   = 40,
    parameter int unsigned ROWS   = 30,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned ROW_W  = 5
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              scan_valid_in,
    input  logic [7:0]        scan_byte_in,
    output logic [7:0]        keypress_out,
    input  logic [15:0]       char_in,
    output logic              wr_valid_out,
    input  logic              wr_ready_in,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [15:0]       wr_data_out,
    output logic [ADDR_W-1:0] cursor_out,
    output logic [ROW_W-1:0]  view_row_out,
    output logic              busy_out,
    output logic [7:0]        drop_count_out
);

    localparam int unsigned       CELLS    = COLS * ROWS;
    localparam logic [ADDR_W-1:0] LastCell = ADDR_W'(CELLS - 1);
    localparam logic [ROW_W-1:0]  LastRow  = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {StIdle, StLookup, StWrite} state_e;

    state_e            state_q, state_d;
    logic              brk_q, brk_d;
    logic              ext_q, ext_d;
    logic [7:0]        key_q, key_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              is_bs_q, is_bs_d;
    logic [ADDR_W-1:0] cursor_q, cursor_d;
    logic [ROW_W-1:0]  view_q, view_d;
    logic              busy_q, busy_d;
    logic [7:0]        drop_q, drop_d;

    logic [31:0]       cur_row;
    logic [ADDR_W-1:0] next_row_start;

    // Enter from the last row wraps back to cell 0.
    always_comb begin
        cur_row = 32'(cursor_q) / COLS;
        if (cur_row + 32'd1 >= ROWS) begin
            next_row_start = '0;
        end else begin
            next_row_start = ADDR_W'((cur_row + 32'd1) * COLS);
        end
    end

    always_comb begin
        state_d    = state_q;
        brk_d      = brk_q;
        ext_d      = ext_q;
        key_d      = key_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        is_bs_d    = is_bs_q;
        cursor_d   = cursor_q;
        view_d     = view_q;
        drop_d     = drop_q;

        if (scan_valid_in && state_q != StIdle && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (scan_valid_in) begin
                    if (scan_byte_in == 8'hF0) begin
                        brk_d = 1'b1;
                    end else if (scan_byte_in == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (brk_q || ext_q) begin
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end else begin
                        key_d   = scan_byte_in;
                        state_d = StLookup;
                    end
                end
            end
            StLookup: begin
                state_d = StIdle;
                if (char_in == 16'd27) begin
                    if (cursor_q != '0) begin
                        wr_addr_d  = cursor_q - 1'b1;
                        wr_data_d  = '0;
                        is_bs_d    = 1'b1;
                        wr_valid_d = 1'b1;
                        state_d    = StWrite;
                    end
                end else if (char_in == 16'd48) begin
                    cursor_d = next_row_start;
                end else if (char_in == 16'd49) begin
                    if (view_q != '0) view_d = view_q - 1'b1;
                end else if (char_in == 16'd50) begin
                    if (view_q != LastRow) view_d = view_q + 1'b1;
                end else if ((char_in >= 16'd1 && char_in <= 16'd47) ||
                             (char_in == 16'd0 && key_q == 8'h29)) begin
                    wr_addr_d  = cursor_q;
                    wr_data_d  = char_in;
                    is_bs_d    = 1'b0;
                    wr_valid_d = 1'b1;
                    state_d    = StWrite;
                end
            end
            StWrite: begin
                if (wr_ready_in) begin
                    wr_valid_d = 1'b0;
                    state_d    = StIdle;
                    if (is_bs_q) begin
                        cursor_d = cursor_q - 1'b1;
                    end else if (cursor_q == LastCell) begin
                        cursor_d = '0;
                    end else begin
                        cursor_d = cursor_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= StIdle;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            key_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            is_bs_q    <= 1'b0;
            cursor_q   <= '0;
            view_q     <= '0;
            busy_q     <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            key_q      <= key_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            is_bs_q    <= is_bs_d;
            cursor_q   <= cursor_d;
            view_q     <= view_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
        end
    end

    assign keypress_out   = key_q;
    assign wr_valid_out   = wr_valid_q;
    assign wr_addr_out    = wr_addr_q;
    assign wr_data_out    = wr_data_q;
    assign cursor_out     = cursor_q;
    assign view_row_out   = view_q;
    assign busy_out       = busy_q;
    assign drop_count_out = drop_q;

endmodule

// File: tb/tb_keystroke_controller.sv
// Bench for keystroke_controller: directed scenarios plus randomized key streams checked
// against a keystroke-level reference model of the terminal state.
module tb_keystroke_controller;

    localparam int COLS   = 40;
    localparam int ROWS   = 30;
    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = 11;
    localparam int ROW_W  = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              scan_valid = 1'b0;
    logic [7:0]        scan_byte = 8'h00;
    logic [7:0]        keypress;
    logic [15:0]       char_code;
    logic              wr_valid;
    logic              wr_ready = 1'b1;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic [ADDR_W-1:0] cursor;
    logic [ROW_W-1:0]  view_row;
    logic              busy;
    logic [7:0]        drops;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int  m_cur, m_view, m_drops;
    bit  m_brk, m_ext;
    logic [26:0] exp_q[$];
    logic [26:0] got_q[$];

    logic [7:0] pool [15] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h66, 8'h5A, 8'h05,
                              8'h06, 8'h29, 8'h0D, 8'h0E, 8'hF0, 8'hE0, 8'h75};

    keystroke_controller #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .ROW_W(ROW_W)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .scan_valid_in (scan_valid),
        .scan_byte_in  (scan_byte),
        .keypress_out  (keypress),
        .char_in       (char_code),
        .wr_valid_out  (wr_valid),
        .wr_ready_in   (wr_ready),
        .wr_addr_out   (wr_addr),
        .wr_data_out   (wr_data),
        .cursor_out    (cursor),
        .view_row_out  (view_row),
        .busy_out      (busy),
        .drop_count_out(drops)
    );

    always #5 clk = ~clk;

    // Stand-in scan-code translator
    function automatic logic [15:0] xlate(input logic [7:0] b);
        case (b)
            8'h1C: return 16'd1;
            8'h32: return 16'd2;
            8'h21: return 16'd3;
            8'h23: return 16'd4;
            8'h24: return 16'd5;
            8'h75: return 16'd20;
            8'h66: return 16'd27;
            8'h5A: return 16'd48;
            8'h05: return 16'd49;
            8'h06: return 16'd50;
            8'h0E: return 16'd60;
            default: return 16'd0;
        endcase
    endfunction

    assign char_code = xlate(keypress);

    always @(negedge clk) begin
        #2;
        if (rst_n && wr_valid && wr_ready) got_q.push_back({wr_addr, wr_data});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic model_key(input logic [7:0] b, output bit will_write);
        int c;
        will_write = 1'b0;
        if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (m_brk || m_ext) begin
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else begin
            c = int'(xlate(b));
            if (c == 27) begin
                if (m_cur > 0) begin
                    exp_q.push_back({11'(m_cur - 1), 16'd0});
                    m_cur = m_cur - 1;
                    will_write = 1'b1;
                end
            end else if (c == 48) begin
                m_cur = ((m_cur / COLS + 1) % ROWS) * COLS;
            end else if (c == 49) begin
                if (m_view > 0) m_view = m_view - 1;
            end else if (c == 50) begin
                if (m_view < ROWS - 1) m_view = m_view + 1;
            end else if ((c >= 1 && c <= 47) || b == 8'h29) begin
                exp_q.push_back({11'(m_cur), 16'(c)});
                m_cur = (m_cur + 1) % CELLS;
                will_write = 1'b1;
            end
        end
    endtask

    function automatic bit q_match();
        if (got_q.size() != exp_q.size()) return 1'b0;
        foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_q();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        scan_valid = 1'b0;
        wr_ready = 1'b1;
        repeat (2) @(negedge clk);
        m_cur = 0; m_view = 0; m_drops = 0; m_brk = 0; m_ext = 0;
        clear_q();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_timeout: busy=%b required 0", busy);
        end
    endtask

    // Send one byte; with stall>0 the write port refuses for that many cycles.
    task automatic press(input logic [7:0] b, input int stall, input bit inject);
        bit ww;
        model_key(b, ww);
        @(negedge clk);
        wr_ready = (stall == 0);
        scan_valid = 1'b1;
        scan_byte = b;
        @(negedge clk);
        scan_valid = 1'b0;
        if (ww && stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                scan_valid = inject && (i == 0);
                scan_byte = 8'h1C;
            end
            if (inject && m_drops < 255) m_drops++;
            @(negedge clk);
            scan_valid = 1'b0;
        end
        wr_ready = 1'b1;
        wait_idle();
    endtask

    task automatic test_reset();
        checks++;
        if ({keypress, wr_valid, wr_addr, wr_data, cursor, view_row, busy, drops} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: key=%h v=%b a=%0d d=%0d cur=%0d view=%0d busy=%b drop=%0d required all 0",
                     keypress, wr_valid, wr_addr, wr_data, cursor, view_row, busy, drops);
        end
    endtask

    task automatic test_basic();
        do_reset();
        press(8'h1C, 0, 0);
        press(8'hF0, 0, 0);
        press(8'h1C, 0, 0);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {11'd0, 16'd1}) begin
            failures++;
            $display("FAIL basic_write: writes=%0d first=%h required 1 write {0,1}", got_q.size(),
                     got_q.size() > 0 ? got_q[0] : 27'h0);
        end
        checks++;
        if (cursor !== 11'd1) begin
            failures++;
            $display("FAIL basic_cursor: cursor=%0d required 1", cursor);
        end
    endtask

    task automatic test_enter_wrap();
        do_reset();
        repeat (39) press(8'h1C, 0, 0);
        clear_q();
        press(8'h5A, 0, 0);
        checks++;
        if (cursor !== 11'd40 || got_q.size() != 0) begin
            failures++;
            $display("FAIL enter_row: cursor=%0d writes=%0d required 40/0", cursor, got_q.size());
        end
        repeat (28) press(8'h5A, 0, 0);
        press(8'h5A, 0, 0);
        checks++;
        if (cursor !== 11'd0) begin
            failures++;
            $display("FAIL enter_last_row: cursor=%0d required 0", cursor);
        end
        repeat (29) press(8'h5A, 0, 0);
        repeat (39) press(8'h1C, 0, 0);
        checks++;
        if (cursor !== 11'd1199) begin
            failures++;
            $display("FAIL cursor_reach: cursor=%0d required 1199", cursor);
        end
        clear_q();
        press(8'h1C, 0, 0);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {11'd1199, 16'd1} || cursor !== 11'd0) begin
            failures++;
            $display("FAIL cell_wrap: writes=%0d cursor=%0d required write@1199 cursor 0",
                     got_q.size(), cursor);
        end
    endtask

    task automatic test_backspace();
        do_reset();
        repeat (5) press(8'h1C, 0, 0);
        clear_q();
        press(8'h66, 0, 0);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {11'd4, 16'd0} || cursor !== 11'd4) begin
            failures++;
            $display("FAIL backspace: writes=%0d cursor=%0d required write {4,0} cursor 4",
                     got_q.size(), cursor);
        end
        do_reset();
        press(8'h66, 0, 0);
        checks++;
        if (got_q.size() != 0 || cursor !== 11'd0) begin
            failures++;
            $display("FAIL backspace_at_0: writes=%0d cursor=%0d required 0/0", got_q.size(), cursor);
        end
    endtask

    task automatic test_stall_drop();
        bit ww;
        do_reset();
        model_key(8'h1C, ww);
        wr_ready = 1'b0;
        @(negedge clk);
        scan_valid = 1'b1;
        scan_byte = 8'h1C;
        @(negedge clk);
        scan_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || wr_valid !== 1'b0 || keypress !== 8'h1C) begin
            failures++;
            $display("FAIL lookup_cycle: busy=%b v=%b key=%h required 1/0/1C", busy, wr_valid, keypress);
        end
        @(negedge clk);
        scan_valid = 1'b1;
        scan_byte = 8'h32;
        @(negedge clk);
        scan_valid = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (wr_valid !== 1'b1 || wr_addr !== 11'd0 || wr_data !== 16'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold: v=%b a=%0d d=%0d busy=%b required 1/0/1/1",
                     wr_valid, wr_addr, wr_data, busy);
        end
        wr_ready = 1'b1;
        @(negedge clk);
        m_drops = 1;
        checks++;
        if (busy !== 1'b0 || drops !== 8'd1 || cursor !== 11'd1) begin
            failures++;
            $display("FAIL stall_done: busy=%b drop=%0d cursor=%0d required 0/1/1", busy, drops, cursor);
        end
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {11'd0, 16'd1}) begin
            failures++;
            $display("FAIL stall_single_write: writes=%0d required 1", got_q.size());
        end
    endtask

    task automatic test_extended();
        do_reset();
        press(8'h1C, 0, 0);
        clear_q();
        press(8'hE0, 0, 0);
        press(8'h75, 0, 0);
        press(8'hE0, 0, 0);
        press(8'hF0, 0, 0);
        press(8'h75, 0, 0);
        checks++;
        if (got_q.size() != 0 || cursor !== 11'd1) begin
            failures++;
            $display("FAIL extended_strip: writes=%0d cursor=%0d required 0/1", got_q.size(), cursor);
        end
        press(8'h75, 0, 0);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {11'd1, 16'd20} || cursor !== 11'd2) begin
            failures++;
            $display("FAIL flags_cleared: writes=%0d cursor=%0d required write {1,20} cursor 2",
                     got_q.size(), cursor);
        end
    endtask

    task automatic test_scroll();
        do_reset();
        repeat (35) press(8'h06, 0, 0);
        checks++;
        if (view_row !== 5'd29) begin
            failures++;
            $display("FAIL scroll_max: view=%0d required 29", view_row);
        end
        repeat (30) press(8'h05, 0, 0);
        press(8'h05, 0, 0);
        checks++;
        if (view_row !== 5'd0 || got_q.size() != 0) begin
            failures++;
            $display("FAIL scroll_min: view=%0d writes=%0d required 0/0", view_row, got_q.size());
        end
    endtask

    task automatic test_space_unmapped();
        do_reset();
        press(8'h0D, 0, 0);
        press(8'h0E, 0, 0);
        checks++;
        if (got_q.size() != 0 || cursor !== 11'd0) begin
            failures++;
            $display("FAIL unmapped: writes=%0d cursor=%0d required 0/0", got_q.size(), cursor);
        end
        press(8'h29, 0, 0);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {11'd0, 16'd0} || cursor !== 11'd1) begin
            failures++;
            $display("FAIL space: writes=%0d cursor=%0d required write {0,0} cursor 1",
                     got_q.size(), cursor);
        end
    endtask

    task automatic test_drop_saturate();
        bit ww;
        do_reset();
        model_key(8'h1C, ww);
        wr_ready = 1'b0;
        @(negedge clk);
        scan_valid = 1'b1;
        scan_byte = 8'h1C;
        repeat (300) @(negedge clk);
        scan_valid = 1'b0;
        m_drops = 255;
        checks++;
        if (drops !== 8'd255) begin
            failures++;
            $display("FAIL drop_saturate: drop=%0d required 255", drops);
        end
        wr_ready = 1'b1;
        wait_idle();
        checks++;
        if (!q_match() || cursor !== 11'(m_cur)) begin
            failures++;
            $display("FAIL drop_write: writes=%0d cursor=%0d required 1/%0d", got_q.size(), cursor, m_cur);
        end
    endtask

    task automatic test_reset_mid_write();
        bit ww;
        do_reset();
        model_key(8'h1C, ww);
        wr_ready = 1'b0;
        @(negedge clk);
        scan_valid = 1'b1;
        scan_byte = 8'h1C;
        @(negedge clk);
        scan_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_write: v=%b required 1", wr_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        test_reset();
        checks++;
        if (got_q.size() != 0) begin
            failures++;
            $display("FAIL reset_no_write: writes=%0d required 0", got_q.size());
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [7:0] b;
        int stall;
        for (int n = 0; n < 300; n++) begin
            b = pool[$urandom_range(0, 14)];
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            press(b, stall, 1'($urandom_range(0, 1)));
            checks++;
            if (cursor !== 11'(m_cur) || view_row !== 5'(m_view) || drops !== 8'(m_drops)) begin
                failures++;
                $display("FAIL random_state[%0d] byte=%h: cur=%0d view=%0d drop=%0d required %0d/%0d/%0d",
                         n, b, cursor, view_row, drops, m_cur, m_view, m_drops);
            end
            checks++;
            if (!q_match()) begin
                failures++;
                $display("FAIL random_writes[%0d] byte=%h: got %0d writes required %0d",
                         n, b, got_q.size(), exp_q.size());
            end
            clear_q();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_enter_wrap();
        test_backspace();
        test_stall_drop();
        test_extended();
        test_scroll();
        test_space_unmapped();
        test_drop_saturate();
        test_reset_mid_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
